// File: rtl/wtm_dot_accumulator.sv
// wtm_dot_accumulator
// Sums LEN consecutive valid products from the Wallace-tree multiplier into one
// dot-product result. Each result goes out through a ready/valid register.
// Partial sums saturate, and the saturation is remembered until the dot product completes.
// A finished result that arrives while the output register is still full is dropped.
// A dropped result sets a sticky flag, because the multiplier cannot stall.

module wtm_dot_accumulator #(
    parameter int PW    = 64,
    parameter int AW    = 72,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             prod_valid,
    input  logic [PW-1:0]    prod,
    input  logic [LEN_W-1:0] len,
    input  logic             clear,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [AW-1:0]    res,
    output logic             res_sat,
    output logic             busy,
    output logic             lost_err
);

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t             state, state_nxt;
    logic [AW-1:0]      acc, acc_nxt;
    logic [LEN_W-1:0]   cnt, cnt_nxt;
    logic [LEN_W-1:0]   tgt, tgt_nxt;
    logic               sat_acc, sat_acc_nxt;
    logic               done;

    logic [AW:0]        cand;
    logic [LEN_W-1:0]   len_eff;
    logic               sat_now;
    logic [AW-1:0]      result;

    // One extra bit catches the carry out of the accumulator.
    // A length of zero is treated as a single-product dot product.
    assign cand    = {1'b0, acc} + (AW+1)'(prod);
    assign len_eff = (len == '0) ? LEN_W'(1) : len;
    assign sat_now = sat_acc | cand[AW];
    assign result  = sat_now ? {AW{1'b1}} : cand[AW-1:0];
    assign busy    = (state == ACC);

    // Accumulator state register; reset discards any partial dot product
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            tgt     <= '0;
            sat_acc <= 1'b0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            tgt     <= tgt_nxt;
            sat_acc <= sat_acc_nxt;
        end
    end

    // Next-state logic: clear beats products; the last product raises done
    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        tgt_nxt     = tgt;
        sat_acc_nxt = sat_acc;
        done        = 1'b0;
        if (clear) begin
            state_nxt   = IDLE;
            acc_nxt     = '0;
            cnt_nxt     = '0;
            sat_acc_nxt = 1'b0;
        end else if (prod_valid) begin
            case (state)
                IDLE: begin
                    tgt_nxt = len_eff;
                    if (len_eff == LEN_W'(1)) begin
                        done = 1'b1;
                    end else begin
                        acc_nxt   = AW'(prod);
                        cnt_nxt   = LEN_W'(1);
                        state_nxt = ACC;
                    end
                end
                ACC: begin
                    if (cnt == tgt - LEN_W'(1)) begin
                        done        = 1'b1;
                        acc_nxt     = '0;
                        cnt_nxt     = '0;
                        sat_acc_nxt = 1'b0;
                        state_nxt   = IDLE;
                    end else begin
                        acc_nxt     = cand[AW] ? {AW{1'b1}} : cand[AW-1:0];
                        sat_acc_nxt = sat_now;
                        cnt_nxt     = cnt + LEN_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output register: load if free or being drained, else drop and flag the loss
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res       <= '0;
            res_sat   <= 1'b0;
            res_valid <= 1'b0;
            lost_err  <= 1'b0;
        end else begin
            if (done) begin
                if (!res_valid || res_ready) begin
                    res       <= result;
                    res_sat   <= sat_now;
                    res_valid <= 1'b1;
                end else begin
                    lost_err  <= 1'b1;
                end
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            if (clear) begin
                lost_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wtm_dot_accumulator.sv
// tb_wtm_dot_accumulator
// The directed scenarios and the randomized traffic are both scored against a reference model.
// The model collects products, adds them with wide arithmetic, and saturates only the final sum.

module tb_wtm_dot_accumulator;

    localparam int PW    = 64;
    localparam int AW    = 66;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rstn;
    logic             prodValid;
    logic [PW-1:0]    prod;
    logic [LEN_W-1:0] len;
    logic             clear;
    logic             resValid;
    logic             resReady;
    logic [AW-1:0]    res;
    logic             resSat;
    logic             busy;
    logic             lostErr;

    int checkCount;
    int errorCount;

    // Reference model state
    logic             mActive;
    int               mCnt;
    int               mTgt;
    logic [127:0]     mSum;
    logic             expValid;
    logic [AW-1:0]    expRes;
    logic             expSat;
    logic             expLost;

    wtm_dot_accumulator #(.PW(PW), .AW(AW), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .prod_valid (prodValid),
        .prod       (prod),
        .len        (len),
        .clear      (clear),
        .res_valid  (resValid),
        .res_ready  (resReady),
        .res        (res),
        .res_sat    (resSat),
        .busy       (busy),
        .lost_err   (lostErr)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observation against its expectation and count it
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Clear all model state, mirroring what a reset means for the block
    task automatic modelReset();
        mActive  = 1'b0;
        mCnt     = 0;
        mTgt     = 0;
        mSum     = '0;
        expValid = 1'b0;
        expRes   = '0;
        expSat   = 1'b0;
        expLost  = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic modelStep(input logic pv, input logic [PW-1:0] p, input logic [LEN_W-1:0] l,
                             input logic clr, input logic rdy);
        logic hs;
        logic finished;
        logic [127:0] limit;
        hs       = expValid && rdy;
        finished = 1'b0;
        limit    = 128'd1 << AW;
        if (clr) begin
            mActive = 1'b0;
            mCnt    = 0;
            mSum    = '0;
            expLost = 1'b0;
            if (hs) expValid = 1'b0;
        end else begin
            if (pv) begin
                if (!mActive) begin
                    mTgt = (l == 0) ? 1 : int'(l);
                    mSum = 128'(p);
                    mCnt = 1;
                end else begin
                    mSum = mSum + 128'(p);
                    mCnt = mCnt + 1;
                end
                if (mCnt == mTgt) begin
                    finished = 1'b1;
                    mActive  = 1'b0;
                end else begin
                    mActive  = 1'b1;
                end
            end
            if (finished) begin
                if (!expValid || rdy) begin
                    expValid = 1'b1;
                    expSat   = (mSum >= limit);
                    expRes   = expSat ? {AW{1'b1}} : mSum[AW-1:0];
                end else begin
                    expLost  = 1'b1;
                end
            end else if (hs) begin
                expValid = 1'b0;
            end
        end
    endtask

    // Compare every output against the model
    task automatic checkAll(input string tag);
        checkOutput({tag, "_valid"}, 128'(resValid), 128'(expValid));
        checkOutput({tag, "_res"},   128'(res),      128'(expRes));
        checkOutput({tag, "_sat"},   128'(resSat),   128'(expSat));
        checkOutput({tag, "_busy"},  128'(busy),     128'(mActive));
        checkOutput({tag, "_lost"},  128'(lostErr),  128'(expLost));
    endtask

    // Drive one cycle of inputs, step the model at the edge, then check just after it
    task automatic applyStimulus(input logic pv, input logic [PW-1:0] p, input logic [LEN_W-1:0] l,
                                 input logic clr, input logic rdy, input string tag);
        prodValid = pv;
        prod      = p;
        len       = l;
        clear     = clr;
        resReady  = rdy;
        @(posedge clk);
        modelStep(pv, p, l, clr, rdy);
        #1;
        checkAll(tag);
    endtask

    // Idle cycles with a fixed ready level
    task automatic idleCycles(input int n, input logic rdy, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, rdy, tag);
    endtask

    logic [PW-1:0] maxProd;
    logic [AW-1:0] allOnes;
    logic [AW-1:0] fourMax;

    // Directed scenarios followed by randomized traffic
    initial begin
        checkCount = 0;
        errorCount = 0;
        maxProd    = {PW{1'b1}};
        allOnes    = {AW{1'b1}};
        fourMax    = {2'b11, 64'hFFFF_FFFF_FFFF_FFFC};
        modelReset();
        rstn      = 1'b0;
        prodValid = 1'b0;
        prod      = '0;
        len       = '0;
        clear     = 1'b0;
        resReady  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkAll("reset");
        rstn = 1'b1;

        // Three products on consecutive cycles
        applyStimulus(1'b1, 64'd121,     8'd3, 1'b0, 1'b1, "t1a");
        applyStimulus(1'b1, 64'd12321,   8'd3, 1'b0, 1'b1, "t1b");
        applyStimulus(1'b1, 64'd1234321, 8'd3, 1'b0, 1'b1, "t1c");
        checkOutput("t1_const_res", 128'(res), 128'd1246763);
        checkOutput("t1_const_busy", 128'(busy), 128'd0);

        // Zero length behaves as one product; then a gap inside a two-product run
        applyStimulus(1'b1, 64'd5184, 8'd0, 1'b0, 1'b1, "t2a");
        checkOutput("t2_const_single", 128'(res), 128'd5184);
        applyStimulus(1'b1, 64'd22, 8'd2, 1'b0, 1'b1, "t2b");
        idleCycles(3, 1'b1, "t2gap");
        applyStimulus(1'b1, 64'd5184, 8'd2, 1'b0, 1'b1, "t2c");
        checkOutput("t2_const_gap", 128'(res), 128'd5206);

        // Stalled output: the second result is dropped and flagged, then drained and cleared
        idleCycles(1, 1'b1, "t3drain");
        applyStimulus(1'b1, 64'd144, 8'd2, 1'b0, 1'b0, "t3a");
        applyStimulus(1'b1, 64'd96,  8'd2, 1'b0, 1'b0, "t3b");
        applyStimulus(1'b1, 64'd22,  8'd2, 1'b0, 1'b0, "t3c");
        applyStimulus(1'b1, 64'd22,  8'd2, 1'b0, 1'b0, "t3d");
        checkOutput("t3_const_held", 128'(res), 128'd240);
        checkOutput("t3_const_lost", 128'(lostErr), 128'd1);
        applyStimulus(1'b0, '0, 8'd2, 1'b0, 1'b1, "t3e");
        checkOutput("t3_const_drained", 128'(resValid), 128'd0);
        applyStimulus(1'b0, '0, 8'd2, 1'b1, 1'b0, "t3f");
        checkOutput("t3_const_cleared", 128'(lostErr), 128'd0);

        // Four max products land just under 2^66; five of them overflow and saturate
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, maxProd, 8'd4, 1'b0, 1'b1, "t4a");
        checkOutput("t4_const_four", 128'(res), 128'(fourMax));
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, maxProd, 8'd5, 1'b0, 1'b1, "t4b");
        checkOutput("t4_const_satres", 128'(res), 128'(allOnes));
        checkOutput("t4_const_sat", 128'(resSat), 128'd1);
        applyStimulus(1'b1, 64'd7, 8'd1, 1'b0, 1'b1, "t4c");
        checkOutput("t4_const_after", 128'(res), 128'd7);

        // Clear together with the last product discards it
        applyStimulus(1'b1, 64'd10, 8'd3, 1'b0, 1'b1, "t5a");
        applyStimulus(1'b1, 64'd20, 8'd3, 1'b0, 1'b1, "t5b");
        applyStimulus(1'b1, 64'd30, 8'd3, 1'b1, 1'b1, "t5c");
        checkOutput("t5_const_busy", 128'(busy), 128'd0);
        checkOutput("t5_const_novalid", 128'(resValid), 128'd0);
        applyStimulus(1'b1, 64'd4, 8'd1, 1'b0, 1'b1, "t5d");
        checkOutput("t5_const_res", 128'(res), 128'd4);

        // Asynchronous reset in the middle of a dot product
        applyStimulus(1'b1, 64'd50, 8'd4, 1'b0, 1'b0, "t6a");
        applyStimulus(1'b1, 64'd60, 8'd4, 1'b0, 1'b0, "t6b");
        #2;
        rstn = 1'b0;
        #1;
        modelReset();
        checkAll("t6rst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        applyStimulus(1'b1, 64'd9, 8'd1, 1'b0, 1'b1, "t6c");
        checkOutput("t6_const_res", 128'(res), 128'd9);

        // Randomized traffic with gaps, stalls, clears, length changes and large products
        for (int i = 0; i < 600; i++) begin
            logic          pv;
            logic          clr;
            logic          rdy;
            logic [PW-1:0] p;
            logic [LEN_W-1:0] l;
            pv  = ($urandom_range(3) != 0);
            clr = ($urandom_range(39) == 0);
            rdy = ($urandom_range(2) != 0);
            l   = LEN_W'($urandom_range(7));
            case ($urandom_range(2))
                0:       p = 64'($urandom_range(1000));
                1:       p = {$urandom(), $urandom()};
                default: p = {32'hFFFF_FFFF, $urandom()};
            endcase
            applyStimulus(pv, p, l, clr, rdy, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
